// File: rtl/ebab_pixel_responder.sv
// -----------------------------------------------------------------------------
// ebab_pixel_responder
//
// Responder end of the EBAB request/acknowledge handshake used by the pixel
// copy engine. Read and write requests are served from a local 32-bit-wide
// pixel RAM, so the copy engine can run against an on-chip frame buffer
// without going through the Avalon bridge. Each request produces exactly one
// acknowledge pulse.
//
// Transaction sequence: IDLE -> WAIT (only if WAIT_STATES>0) -> ACCESS -> ACK
// -> RECOVER -> IDLE. acknowledge rises WAIT_STATES+1 edges after the edge
// that samples the request. Request samples are at least WAIT_STATES+4
// cycles apart.
//
// Parameters:
//   BASE_ADDR    byte address of the first RAM byte
//   MEM_AW       log2 of the window size in bytes (>=3); RAM has 2**(MEM_AW-2) words
//   WAIT_STATES  extra cycles inserted before each access (0..15)
//   ERR_RDATA    read_data value returned for out-of-window reads
//
// Ports:
//   CLOCK_50     clock, all logic on the rising edge
//   reset_n      asynchronous active-low reset (RAM contents are kept)
//   address      byte address; bits [1:0] are ignored, lanes come from byte_enable
//   byte_enable  write lane mask, bit i enables write_data[8i+7:8i]
//   read/write   request strobes, held by the initiator until acknowledge
//   write_data   write data
//   acknowledge  one-cycle completion pulse
//   read_data    read result, held until the next read completes
//   err_count    saturating count of out-of-window accesses
//   proto_err    sticky flag: read and write were sampled high together
//   rd_count     completed in-window reads  (only with EBAB_RESP_STATS_EN)
//   wr_count     completed in-window writes (only with EBAB_RESP_STATS_EN)
//
// Build option: define EBAB_RESP_STATS_EN to build the rd_count/wr_count
// counters; otherwise both outputs are tied to zero.
// -----------------------------------------------------------------------------
module ebab_pixel_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0800_0000,
  parameter int          MEM_AW      = 17,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ERR_RDATA   = 32'h0000_0000
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic [3:0]  byte_enable,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] write_data,
  output logic        acknowledge,
  output logic [31:0] read_data,
  output logic [7:0]  err_count,
  output logic        proto_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int IW    = MEM_AW - 2;
  localparam int DEPTH = 2 ** IW;
  // One past the last window byte, kept at 33 bits so the window cannot wrap.
  localparam logic [32:0] WIN_END   = {1'b0, BASE_ADDR} + (33'd1 << MEM_AW);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_ACK,
    S_RECOVER
  } state_t;

  state_t state_reg, state_next;

  logic [3:0]    wait_cnt_reg;
  logic [IW-1:0] idx_reg;
  logic          in_win_reg;
  logic          is_write_reg;
  logic [3:0]    be_reg;
  logic [31:0]   wdata_reg;
  logic [31:0]   rd_word_reg;

  logic [31:0]   mem [0:DEPTH-1];

  // Request decode. The word index is the word part of (address - BASE_ADDR),
  // computed on the low MEM_AW bits only; the borrow out of the byte bits
  // keeps it exact for a BASE_ADDR that is not word aligned.
  logic          req;
  logic          req_borrow;
  logic [IW-1:0] req_idx;
  logic          req_in_win;
  logic [IW-1:0] rd_idx;
  logic          mem_we;

  assign req        = read | write;
  assign req_borrow = (address[1:0] < BASE_ADDR[1:0]);
  assign req_idx    = address[MEM_AW-1:2] - BASE_ADDR[MEM_AW-1:2] - IW'(req_borrow);
  assign req_in_win = (address >= BASE_ADDR) && ({1'b0, address} < WIN_END);

  // While idle the RAM read port follows the incoming address. That way the
  // word is already registered in rd_word_reg during ACCESS, even when there
  // are no wait states.
  assign rd_idx = (state_reg == S_IDLE) ? req_idx : idx_reg;
  // state_reg is forced to IDLE by reset, so an aborted write never commits.
  assign mem_we = (state_reg == S_ACCESS) && is_write_reg && in_win_reg;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (req) state_next = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:    if (wait_cnt_reg == 4'd0) state_next = S_ACCESS;
      S_ACCESS:  state_next = S_ACK;
      S_ACK:     state_next = S_RECOVER;
      S_RECOVER: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register, request capture and completion outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 4'd0;
      idx_reg      <= '0;
      in_win_reg   <= 1'b0;
      is_write_reg <= 1'b0;
      be_reg       <= 4'd0;
      wdata_reg    <= 32'd0;
      acknowledge  <= 1'b0;
      read_data    <= 32'd0;
      err_count    <= 8'd0;
      proto_err    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (req) begin
            idx_reg      <= req_idx;
            in_win_reg   <= req_in_win;
            // A simultaneous read and write is treated as a write.
            is_write_reg <= write;
            be_reg       <= byte_enable;
            wdata_reg    <= write_data;
            wait_cnt_reg <= WAIT_LOAD;
            if (read && write) proto_err <= 1'b1;
          end
        end
        S_WAIT: begin
          if (wait_cnt_reg != 4'd0) wait_cnt_reg <= wait_cnt_reg - 4'd1;
        end
        S_ACCESS: begin
          acknowledge <= 1'b1;
          if (!is_write_reg) read_data <= in_win_reg ? rd_word_reg : ERR_RDATA;
          if (!in_win_reg && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
        end
        S_ACK: begin
          acknowledge <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel RAM: byte-lane write, registered read (read-first)
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_reg[i]) mem[idx_reg][8*i +: 8] <= wdata_reg[8*i +: 8];
      end
    end
    rd_word_reg <= mem[rd_idx];
  end

  // ---------------------------------------------------------------------------
  // Optional transaction statistics
  // ---------------------------------------------------------------------------
`ifdef EBAB_RESP_STATS_EN
  logic [15:0] rd_count_reg;
  logic [15:0] wr_count_reg;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      rd_count_reg <= 16'd0;
      wr_count_reg <= 16'd0;
    end else if ((state_reg == S_ACCESS) && in_win_reg) begin
      if (is_write_reg) begin
        if (wr_count_reg != 16'hFFFF) wr_count_reg <= wr_count_reg + 16'd1;
      end else begin
        if (rd_count_reg != 16'hFFFF) rd_count_reg <= rd_count_reg + 16'd1;
      end
    end
  end

  assign rd_count = rd_count_reg;
  assign wr_count = wr_count_reg;
`else
  assign rd_count = 16'd0;
  assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_ebab_pixel_responder.sv
// -----------------------------------------------------------------------------
// tb_ebab_pixel_responder
//
// Directed bench for ebab_pixel_responder. There are two instances:
//   u_dut : zero wait states, 128 KiB window, ERR_RDATA = 32'hDEADBEEF
//   u_ws  : three wait states, 256 B window
// Both instances share the clock and reset.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ebab_pixel_responder;

  localparam logic [31:0] BASE = 32'h0800_0000;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
`ifdef EBAB_RESP_STATS_EN
  localparam int EXP_STAT = 500;
`else
  localparam int EXP_STAT = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;
  logic        m_rd, m_wr, m_ack, m_proto;
  logic [7:0]  m_err;
  logic [15:0] m_rdc, m_wrc;

  logic [31:0] w_addr, w_wdata, w_rdata;
  logic [3:0]  w_be;
  logic        w_rd, w_wr, w_ack, w_proto;
  logic [7:0]  w_err;
  logic [15:0] w_rdc, w_wrc;

  int errors = 0;
  int checks = 0;

  ebab_pixel_responder #(
    .BASE_ADDR(BASE), .MEM_AW(17), .WAIT_STATES(0), .ERR_RDATA(ERRD)
  ) u_dut (
    .CLOCK_50(clk), .reset_n(reset_n), .address(m_addr), .byte_enable(m_be),
    .read(m_rd), .write(m_wr), .write_data(m_wdata), .acknowledge(m_ack),
    .read_data(m_rdata), .err_count(m_err), .proto_err(m_proto),
    .rd_count(m_rdc), .wr_count(m_wrc)
  );

  ebab_pixel_responder #(
    .BASE_ADDR(BASE), .MEM_AW(8), .WAIT_STATES(3), .ERR_RDATA(32'h0)
  ) u_ws (
    .CLOCK_50(clk), .reset_n(reset_n), .address(w_addr), .byte_enable(w_be),
    .read(w_rd), .write(w_wr), .write_data(w_wdata), .acknowledge(w_ack),
    .read_data(w_rdata), .err_count(w_err), .proto_err(w_proto),
    .rd_count(w_rdc), .wr_count(w_wrc)
  );

  // One transaction. The first posedge after driving is the sampling edge.
  // lat = edges after the sampling edge until acknowledge is seen (-1 on timeout).
  // pulses = number of sampled cycles with acknowledge high, counted over the
  // ack cycle and the two cycles after it. The request is dropped right after
  // the ack edge. On return the responder is back in IDLE.
  task automatic bus_op(input bit ws, input bit wr, input bit rd, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] d,
                        output int lat, output int pulses, output logic [31:0] rdata);
    @(negedge clk);
    if (ws) begin w_addr = a; w_be = be; w_wdata = d; w_wr = wr; w_rd = rd; end
    else    begin m_addr = a; m_be = be; m_wdata = d; m_wr = wr; m_rd = rd; end
    lat = -1; pulses = 0; rdata = 32'hx;
    @(posedge clk);
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (ws ? w_ack : m_ack) begin
        lat = i; pulses = 1; rdata = ws ? w_rdata : m_rdata;
      end
    end
    if (ws) begin w_wr = 1'b0; w_rd = 1'b0; end
    else    begin m_wr = 1'b0; m_rd = 1'b0; end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (ws ? w_ack : m_ack) pulses++;
    end
    $display("txn ws=%0d wr=%0d rd=%0d addr=%h be=%b wdata=%h -> lat=%0d pulses=%0d rdata=%h",
             ws, wr, rd, a, be, d, lat, pulses, rdata);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (m_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b expected 0", m_ack); end
    checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", m_rdata); end
    checks++; if (m_err !== 8'h0) begin errors++; $display("FAIL rst_err: got %0d expected 0", m_err); end
    checks++; if (m_proto !== 1'b0) begin errors++; $display("FAIL rst_proto: got %b expected 0", m_proto); end
    checks++; if (m_rdc !== 16'h0 || m_wrc !== 16'h0) begin
      errors++; $display("FAIL rst_stats: got rd=%0d wr=%0d expected 0/0", m_rdc, m_wrc);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic_rw();
    int lat, p; logic [31:0] rd;
    bus_op(0, 1, 0, BASE + 4, 4'b1111, 32'h0, lat, p, rd);  // known prior contents
    bus_op(0, 1, 0, BASE + 4, 4'b0001, 32'hAABBCC11, lat, p, rd);
    checks++; if (lat !== 1 || p !== 1) begin errors++; $display("FAIL t1_wr_ack: got lat=%0d pulses=%0d expected 1/1", lat, p); end
    bus_op(0, 0, 1, BASE + 4, 4'b1111, 32'h0, lat, p, rd);
    checks++; if (lat !== 1 || p !== 1) begin errors++; $display("FAIL t1_rd_ack: got lat=%0d pulses=%0d expected 1/1", lat, p); end
    checks++; if (rd !== 32'h0000_0011) begin errors++; $display("FAIL t1_rd_data: got %h expected 00000011", rd); end
    // A write must leave read_data holding the previous read result.
    bus_op(0, 1, 0, BASE + 4, 4'b1111, 32'h0, lat, p, rd);
    checks++; if (rd !== 32'h0000_0011) begin errors++; $display("FAIL t1_rdata_hold: got %h expected 00000011", rd); end
    // A byte_enable=0000 write acks but leaves the RAM unchanged.
    bus_op(0, 1, 0, BASE + 4, 4'b0000, 32'hFFFF_FFFF, lat, p, rd);
    checks++; if (lat !== 1) begin errors++; $display("FAIL t1_be0_ack: got lat=%0d expected 1", lat); end
    bus_op(0, 0, 1, BASE + 4, 4'b1111, 32'h0, lat, p, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL t1_be0_data: got %h expected 00000000", rd); end
  endtask

  task automatic test_window();
    int lat, p; logic [31:0] rd;
    bus_op(0, 1, 0, BASE, 4'b1111, 32'h1122_3344, lat, p, rd);
    bus_op(0, 0, 1, BASE - 1, 4'b1111, 32'h0, lat, p, rd);
    checks++; if (lat !== 1 || rd !== ERRD || m_err !== 8'd1) begin
      errors++; $display("FAIL t3_below: got lat=%0d rdata=%h err=%0d expected 1/deadbeef/1", lat, rd, m_err);
    end
    bus_op(0, 0, 1, BASE + 32'h2_0000, 4'b1111, 32'h0, lat, p, rd);
    checks++; if (lat !== 1 || rd !== ERRD || m_err !== 8'd2) begin
      errors++; $display("FAIL t3_above: got lat=%0d rdata=%h err=%0d expected 1/deadbeef/2", lat, rd, m_err);
    end
    // An out-of-window write at an address that aliases word 0 must be dropped.
    bus_op(0, 1, 0, BASE + 32'h2_0000, 4'b1111, 32'hFFFF_FFFF, lat, p, rd);
    bus_op(0, 0, 1, BASE, 4'b1111, 32'h0, lat, p, rd);
    checks++; if (rd !== 32'h1122_3344 || m_err !== 8'd3) begin
      errors++; $display("FAIL t3_untouched: got rdata=%h err=%0d expected 11223344/3", rd, m_err);
    end
    bus_op(0, 1, 0, BASE + 32'h1_FFFC, 4'b1111, 32'hAA55_AA55, lat, p, rd);
    bus_op(0, 0, 1, BASE + 32'h1_FFFC, 4'b1111, 32'h0, lat, p, rd);
    checks++; if (rd !== 32'hAA55_AA55 || m_err !== 8'd3) begin
      errors++; $display("FAIL t3_last_word: got rdata=%h err=%0d expected aa55aa55/3", rd, m_err);
    end
    for (int i = 0; i < 260; i++) bus_op(0, 0, 1, 32'h0, 4'b1111, 32'h0, lat, p, rd);
    checks++; if (m_err !== 8'd255) begin errors++; $display("FAIL t3_saturate: got %0d expected 255", m_err); end
  endtask

  task automatic test_proto_err();
    int lat, p; logic [31:0] rd;
    checks++; if (m_proto !== 1'b0) begin errors++; $display("FAIL t4_before: got %b expected 0", m_proto); end
    bus_op(0, 1, 1, BASE + 8, 4'b1111, 32'h1234_5678, lat, p, rd);
    checks++; if (lat !== 1 || m_proto !== 1'b1) begin
      errors++; $display("FAIL t4_flag: got lat=%0d proto=%b expected 1/1", lat, m_proto);
    end
    bus_op(0, 0, 1, BASE + 8, 4'b1111, 32'h0, lat, p, rd);
    checks++; if (rd !== 32'h1234_5678 || m_proto !== 1'b1) begin
      errors++; $display("FAIL t4_written: got rdata=%h proto=%b expected 12345678/1", rd, m_proto);
    end
  endtask

  task automatic test_wait_states();
    int lat, p, t1, t2, nack; logic [31:0] rd;
    bus_op(1, 1, 0, BASE, 4'b1111, 32'hCAFE_F00D, lat, p, rd);
    checks++; if (lat !== 4 || p !== 1) begin errors++; $display("FAIL t2_wr_ack: got lat=%0d pulses=%0d expected 4/1", lat, p); end
    bus_op(1, 0, 1, BASE, 4'b1111, 32'h0, lat, p, rd);
    checks++; if (lat !== 4 || rd !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL t2_rd: got lat=%0d rdata=%h expected 4/cafef00d", lat, rd);
    end
    // Hold read high: the request is re-sampled every WAIT_STATES+4 = 7 cycles.
    @(negedge clk);
    w_addr = BASE; w_be = 4'b1111; w_rd = 1'b1;
    t1 = -1; t2 = -1; nack = 0;
    for (int i = 1; i <= 19; i++) begin
      @(posedge clk); #1;
      if (w_ack) begin
        nack++;
        if (t1 < 0) t1 = i; else if (t2 < 0) t2 = i;
      end
    end
    w_rd = 1'b0;
    repeat (2) @(posedge clk);
    $display("txn ws=1 held read -> acks=%0d first=%0d second=%0d", nack, t1, t2);
    checks++; if (t1 !== 5) begin errors++; $display("FAIL t2_held_first: got edge %0d expected 5", t1); end
    checks++; if (t2 - t1 !== 7 || nack !== 3) begin
      errors++; $display("FAIL t2_period: got gap=%0d acks=%0d expected 7/3", t2 - t1, nack);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] model [16:47];
    int lat, p, acks, bad;
    logic [31:0] rd, d, a;
    logic [3:0] be;
    int w;
    test_reset();
    acks = 0; bad = 0;
    for (int j = 0; j < 500; j++) begin
      w  = 16 + (j % 32);
      d  = $urandom;
      be = (j < 32) ? 4'b1111 : 4'($urandom_range(0, 15));
      bus_op(0, 1, 0, BASE + 32'(4 * w), be, d, lat, p, rd);
      if (lat == 1 && p == 1) acks++;
      for (int b = 0; b < 4; b++) if (be[b]) model[w][8*b +: 8] = d[8*b +: 8];
      w = 16 + $urandom_range(0, (j < 31) ? j : 31);
      a = BASE + 32'(4 * w) + 32'($urandom_range(0, 3));
      bus_op(0, 0, 1, a, 4'b1111, 32'h0, lat, p, rd);
      if (lat == 1 && p == 1) acks++;
      checks++;
      if (rd !== model[w]) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL t6_rd_data: word %0d got %h expected %h", w, rd, model[w]);
      end
    end
    checks++; if (acks !== 1000) begin errors++; $display("FAIL t6_acks: got %0d expected 1000", acks); end
    checks++; if (m_rdc !== 16'(EXP_STAT) || m_wrc !== 16'(EXP_STAT)) begin
      errors++; $display("FAIL t6_stats: got rd=%0d wr=%0d expected %0d/%0d", m_rdc, m_wrc, EXP_STAT, EXP_STAT);
    end
  endtask

  task automatic test_reset_abort();
    int lat, p; logic [31:0] rd;
    bus_op(0, 0, 1, 32'h0, 4'b1111, 32'h0, lat, p, rd);  // makes err_count nonzero
    bus_op(0, 1, 1, BASE + 8, 4'b1111, 32'h0, lat, p, rd);  // makes proto_err set
    bus_op(1, 1, 0, BASE + 12, 4'b1111, 32'h5555_AAAA, lat, p, rd);
    @(negedge clk);
    w_addr = BASE + 12; w_be = 4'b1111; w_wdata = 32'h1212_1212; w_wr = 1'b1;
    @(posedge clk); #1;   // sampling edge, u_ws is now in WAIT
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++; if (w_ack !== 1'b0) begin errors++; $display("FAIL t5_ack: got %b expected 0", w_ack); end
    checks++; if (m_err !== 8'd0 || m_proto !== 1'b0 || m_rdc !== 16'd0 || m_wrc !== 16'd0 || w_err !== 8'd0) begin
      errors++; $display("FAIL t5_counters: got err=%0d proto=%b rd=%0d wr=%0d ws_err=%0d expected all 0",
                         m_err, m_proto, m_rdc, m_wrc, w_err);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    w_wr = 1'b0;
    reset_n = 1'b1;
    bus_op(1, 0, 1, BASE + 12, 4'b1111, 32'h0, lat, p, rd);
    checks++; if (lat !== 4 || rd !== 32'h5555_AAAA) begin
      errors++; $display("FAIL t5_old_value: got lat=%0d rdata=%h expected 4/5555aaaa", lat, rd);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    m_addr = '0; m_wdata = '0; m_be = '0; m_rd = 1'b0; m_wr = 1'b0;
    w_addr = '0; w_wdata = '0; w_be = '0; w_rd = 1'b0; w_wr = 1'b0;
    test_reset();
    test_basic_rw();
    test_window();
    test_proto_err();
    test_wait_states();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
